// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh injection path.
// Provides the lane flit layout, the lane occupancy states and the width
// constants derived from the mesh build macros (defaults given here when the
// build does not define them).

`ifndef MESH_X_SIZE_LOG2
`define MESH_X_SIZE_LOG2 2
`endif
`ifndef MESH_Y_SIZE_LOG2
`define MESH_Y_SIZE_LOG2 2
`endif
`ifndef MESH_W
`define MESH_W 16
`endif
`ifndef NUM_SHARED_MATCH_PE
`define NUM_SHARED_MATCH_PE 4
`endif

package mesh_pkg;

    localparam int MESH_X_LOG2    = `MESH_X_SIZE_LOG2;
    localparam int MESH_Y_LOG2    = `MESH_Y_SIZE_LOG2;
    localparam int MESH_PAYLOAD_W = `MESH_W;
    localparam int MESH_NUM_LANE  = `NUM_SHARED_MATCH_PE;
    localparam int MESH_FLIT_W    = MESH_X_LOG2 + MESH_Y_LOG2 + MESH_PAYLOAD_W;

    // One flit as held by an injection lane, most significant field first.
    typedef struct packed {
        logic [MESH_X_LOG2-1:0]    dst_x;
        logic [MESH_Y_LOG2-1:0]    dst_y;
        logic [MESH_PAYLOAD_W-1:0] payload;
    } lane_flit_t;

    // Occupancy of one injection lane holding register.
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/mesh_inject_scheduler_if.sv
// Bundle of the requester-side and lane-side signals of the scheduler.
// slave  : view of the scheduler itself (takes requests, drives lanes).
// master : view of the surrounding logic (requesters, router cluster, config).
// Requester side : cfg_en, req_valid, req_dst_x, req_dst_y, req_payload, req_ready
// Lane side      : o_l_valid, o_l_dst_x, o_l_dst_y, o_l_payload, o_l_ready
// Status         : o_idle, o_grant_cnt

interface mesh_inject_scheduler_if
    import mesh_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int NUM_LANE = MESH_NUM_LANE,
    parameter int X_LOG2   = MESH_X_LOG2,
    parameter int Y_LOG2   = MESH_Y_LOG2,
    parameter int W        = MESH_PAYLOAD_W
);

    logic                       cfg_en;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*X_LOG2-1:0]  req_dst_x;
    logic [NUM_REQ*Y_LOG2-1:0]  req_dst_y;
    logic [NUM_REQ*W-1:0]       req_payload;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_LANE-1:0]        o_l_valid;
    logic [NUM_LANE*X_LOG2-1:0] o_l_dst_x;
    logic [NUM_LANE*Y_LOG2-1:0] o_l_dst_y;
    logic [NUM_LANE*W-1:0]      o_l_payload;
    logic [NUM_LANE-1:0]        o_l_ready;
    logic                       o_idle;
    logic [31:0]                o_grant_cnt;

    modport slave (
        input  cfg_en, req_valid, req_dst_x, req_dst_y, req_payload, o_l_ready,
        output req_ready, o_l_valid, o_l_dst_x, o_l_dst_y, o_l_payload,
               o_idle, o_grant_cnt
    );

    modport master (
        output cfg_en, req_valid, req_dst_x, req_dst_y, req_payload, o_l_ready,
        input  req_ready, o_l_valid, o_l_dst_x, o_l_dst_y, o_l_payload,
               o_idle, o_grant_cnt
    );

endinterface

// File: rtl/mesh_inject_lane_reg.sv
// Holding register for one local injection lane.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : a granted flit is written this cycle
//   load_data  : the granted flit
//   out_ready  : router lane accepts the held flit
//   out_valid  : a flit is held (FULL)
//   out_data   : the held flit, stable while FULL and not accepted
//   lane_free  : lane can take a new flit this cycle (empty, or draining now)

module mesh_inject_lane_reg
    import mesh_pkg::*;
#(
    parameter int FLIT_W = MESH_FLIT_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [FLIT_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_data,
    output logic              lane_free
);

    lane_state_t state, state_next;

    // Occupancy register; reset discards any held flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LANE_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load always wins (refill on the same cycle as a drain); otherwise a
    // held flit leaves only when the router takes it.
    always_comb begin
        state_next = state;
        case (state)
            LANE_EMPTY: begin
                if (load) begin
                    state_next = LANE_FULL;
                end
            end
            LANE_FULL: begin
                if (load) begin
                    state_next = LANE_FULL;
                end else if (out_ready) begin
                    state_next = LANE_EMPTY;
                end
            end
            default: state_next = LANE_EMPTY;
        endcase
    end

    // Flit data only changes on a load, so a stalled flit stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    assign out_valid = (state == LANE_FULL);
    assign lane_free = (state == LANE_EMPTY) || out_ready;

endmodule

// File: rtl/mesh_inject_scheduler.sv
// Round-robin scheduler of match-engine requesters onto the local injection
// lanes of one mesh router cluster.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mesh_inject_scheduler_if.slave carrying the requester handshake
//              (req_*), the lane outputs (o_l_*), cfg_en and status
//              (o_idle, o_grant_cnt)
// Requests are granted combinationally; the k-th valid requester counted
// from rr_ptr gets the k-th free lane in ascending lane order.

module mesh_inject_scheduler
    import mesh_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int NUM_LANE = MESH_NUM_LANE,
    parameter int X_LOG2   = MESH_X_LOG2,
    parameter int Y_LOG2   = MESH_Y_LOG2,
    parameter int W        = MESH_PAYLOAD_W
)(
    input  logic                  clk,
    input  logic                  rst,
    mesh_inject_scheduler_if.slave bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FLIT_W = X_LOG2 + Y_LOG2 + W;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [31:0]         grant_cnt;
    logic [31:0]         grant_num;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_LANE-1:0] lane_free;
    logic [NUM_LANE-1:0] lane_load;
    logic [NUM_LANE-1:0] lane_valid;
    logic [FLIT_W-1:0]   req_flit       [NUM_REQ];
    logic [FLIT_W-1:0]   lane_load_data [NUM_LANE];
    logic [FLIT_W-1:0]   lane_data      [NUM_LANE];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign req_flit[r] = {bus.req_dst_x[r*X_LOG2 +: X_LOG2],
                              bus.req_dst_y[r*Y_LOG2 +: Y_LOG2],
                              bus.req_payload[r*W +: W]};
    end

    // Arbitration: walk the requesters circularly from rr_ptr and hand each
    // valid one the lowest free lane not yet taken this cycle. Once the lanes
    // run out nothing further is granted. Reset blocks every grant so that
    // req_ready reads zero while rst is asserted.
    always_comb begin
        int                 idx_i;
        logic [PTR_W-1:0]   idx;
        logic [PTR_W-1:0]   last;
        logic               found;
        logic               any_grant;

        idx_i     = 0;
        idx       = '0;
        last      = rr_ptr;
        found     = 1'b0;
        any_grant = 1'b0;
        grant     = '0;
        lane_load = '0;
        grant_num = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            lane_load_data[l] = '0;
        end

        if (bus.cfg_en && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_i = int'(rr_ptr) + k;
                if (idx_i >= NUM_REQ) begin
                    idx_i = idx_i - NUM_REQ;
                end
                idx = PTR_W'(idx_i);
                if (bus.req_valid[idx]) begin
                    found = 1'b0;
                    for (int l = 0; l < NUM_LANE; l++) begin
                        if (!found && lane_free[l] && !lane_load[l]) begin
                            found             = 1'b1;
                            lane_load[l]      = 1'b1;
                            lane_load_data[l] = req_flit[idx];
                        end
                    end
                    if (found) begin
                        grant[idx] = 1'b1;
                        grant_num  = grant_num + 32'd1;
                        last       = idx;
                        any_grant  = 1'b1;
                    end
                end
            end
        end

        rr_ptr_next = rr_ptr;
        if (any_grant) begin
            rr_ptr_next = PTR_W'((int'(last) + 1) % NUM_REQ);
        end
    end

    // Pointer and accepted-request counter; the counter wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_cnt <= '0;
        end else begin
            rr_ptr    <= rr_ptr_next;
            grant_cnt <= grant_cnt + grant_num;
        end
    end

    for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
        mesh_inject_lane_reg #(
            .FLIT_W (FLIT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (lane_load[g]),
            .load_data (lane_load_data[g]),
            .out_ready (bus.o_l_ready[g]),
            .out_valid (lane_valid[g]),
            .out_data  (lane_data[g]),
            .lane_free (lane_free[g])
        );

        assign bus.o_l_dst_x[g*X_LOG2 +: X_LOG2] = lane_data[g][FLIT_W-1 -: X_LOG2];
        assign bus.o_l_dst_y[g*Y_LOG2 +: Y_LOG2] = lane_data[g][W +: Y_LOG2];
        assign bus.o_l_payload[g*W +: W]         = lane_data[g][0 +: W];
    end

    assign bus.o_l_valid   = lane_valid;
    assign bus.req_ready   = grant;
    assign bus.o_grant_cnt = grant_cnt;
    assign bus.o_idle      = !(|lane_valid) && !(|grant);

endmodule

// File: tb/tb_mesh_inject_scheduler.sv
// Self-checking bench for mesh_inject_scheduler: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.

module tb_mesh_inject_scheduler;
    import mesh_pkg::*;

    localparam int NUM_REQ  = 8;
    localparam int NUM_LANE = 4;
    localparam int XW       = MESH_X_LOG2;
    localparam int YW       = MESH_Y_LOG2;
    localparam int PW       = MESH_PAYLOAD_W;

    logic clk = 1'b0;
    logic rst;

    mesh_inject_scheduler_if #(
        .NUM_REQ(NUM_REQ), .NUM_LANE(NUM_LANE), .X_LOG2(XW), .Y_LOG2(YW), .W(PW)
    ) bus ();

    mesh_inject_scheduler #(
        .NUM_REQ(NUM_REQ), .NUM_LANE(NUM_LANE), .X_LOG2(XW), .Y_LOG2(YW), .W(PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: lane occupancy and contents, pointer, counter.
    bit                 mFull [NUM_LANE];
    lane_flit_t         mFlit [NUM_LANE];
    int                 mPtr;
    logic [31:0]        mCnt;
    logic [NUM_REQ-1:0] mGrant;
    int                 mLaneSrc [NUM_LANE];
    int                 mNum;
    int                 mLast;
    logic [NUM_REQ-1:0] lastReady;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int l = 0; l < NUM_LANE; l++) begin
            mFull[l] = 1'b0;
            mFlit[l] = '0;
        end
        mPtr = 0;
        mCnt = '0;
    endtask

    function automatic lane_flit_t reqFlit(input int r);
        lane_flit_t f;
        f.dst_x   = bus.req_dst_x[r*XW +: XW];
        f.dst_y   = bus.req_dst_y[r*YW +: YW];
        f.payload = bus.req_payload[r*PW +: PW];
        return f;
    endfunction

    // Pair the free lanes (ascending) with the valid requesters (circular
    // from the pointer) one-to-one until either list is exhausted.
    task automatic predictGrants();
        int freeLanes[$];
        int askers[$];
        int l;
        int r;
        mGrant = '0;
        mNum   = 0;
        mLast  = -1;
        for (int i = 0; i < NUM_LANE; i++) mLaneSrc[i] = -1;
        if (bus.cfg_en && !rst) begin
            for (int i = 0; i < NUM_LANE; i++)
                if (!mFull[i] || bus.o_l_ready[i]) freeLanes.push_back(i);
            for (int k = 0; k < NUM_REQ; k++)
                if (bus.req_valid[(mPtr + k) % NUM_REQ]) askers.push_back((mPtr + k) % NUM_REQ);
            while (freeLanes.size() > 0 && askers.size() > 0) begin
                l = freeLanes.pop_front();
                r = askers.pop_front();
                mGrant[r]   = 1'b1;
                mLaneSrc[l] = r;
                mNum++;
                mLast = r;
            end
        end
    endtask

    task automatic commitModel();
        for (int l = 0; l < NUM_LANE; l++) begin
            if (mLaneSrc[l] >= 0) begin
                mFull[l] = 1'b1;
                mFlit[l] = reqFlit(mLaneSrc[l]);
            end else if (mFull[l] && bus.o_l_ready[l]) begin
                mFull[l] = 1'b0;
            end
        end
        if (mNum > 0) mPtr = (mLast + 1) % NUM_REQ;
        mCnt = mCnt + 32'(mNum);
    endtask

    task automatic checkLanes();
        logic [NUM_LANE-1:0] expValid;
        for (int l = 0; l < NUM_LANE; l++) expValid[l] = mFull[l];
        checkOutput("lane_valid", 64'(bus.o_l_valid), 64'(expValid));
        for (int l = 0; l < NUM_LANE; l++) begin
            if (mFull[l]) begin
                checkOutput($sformatf("lane%0d_x", l), 64'(bus.o_l_dst_x[l*XW +: XW]), 64'(mFlit[l].dst_x));
                checkOutput($sformatf("lane%0d_y", l), 64'(bus.o_l_dst_y[l*YW +: YW]), 64'(mFlit[l].dst_y));
                checkOutput($sformatf("lane%0d_payload", l), 64'(bus.o_l_payload[l*PW +: PW]), 64'(mFlit[l].payload));
            end
        end
        checkOutput("grant_cnt", 64'(bus.o_grant_cnt), 64'(mCnt));
        checkOutput("rr_ptr", 64'(dut.rr_ptr), 64'(mPtr));
    endtask

    task automatic randomizeFields();
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_dst_x[r*XW +: XW]   = XW'($urandom);
            bus.req_dst_y[r*YW +: YW]   = YW'($urandom);
            bus.req_payload[r*PW +: PW] = PW'($urandom);
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, check the
    // combinational grant and idle, then cross the edge and check the lanes.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_LANE-1:0] ready, input logic en);
        bit anyFull;
        bus.req_valid = valid;
        bus.o_l_ready = ready;
        bus.cfg_en    = en;
        #1;
        predictGrants();
        anyFull = 1'b0;
        for (int l = 0; l < NUM_LANE; l++) anyFull |= mFull[l];
        lastReady = bus.req_ready;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(mGrant));
        checkOutput("idle", 64'(bus.o_idle), 64'(!anyFull && (mGrant == '0)));
        @(posedge clk);
        commitModel();
        #1;
        checkLanes();
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.req_valid = '1;
        #1;
        modelReset();
        checkOutput("rst_valid", 64'(bus.o_l_valid), 64'd0);
        checkOutput("rst_cnt", 64'(bus.o_grant_cnt), 64'd0);
        checkOutput("rst_ptr", 64'(dut.rr_ptr), 64'd0);
        checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_idle", 64'(bus.o_idle), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.cfg_en      = 1'b1;
        bus.req_valid   = '0;
        bus.req_dst_x   = '0;
        bus.req_dst_y   = '0;
        bus.req_payload = '0;
        bus.o_l_ready   = '1;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] single request");
        randomizeFields();
        bus.req_dst_x[3*XW +: XW]   = XW'(1);
        bus.req_dst_y[3*YW +: YW]   = YW'(2);
        bus.req_payload[3*PW +: PW] = PW'(16'hAB);
        applyStimulus(8'b0000_1000, 4'hF, 1'b1);
        checkOutput("single_ready", 64'(lastReady), 64'h08);
        checkOutput("single_valid", 64'(bus.o_l_valid), 64'h1);
        checkOutput("single_x", 64'(bus.o_l_dst_x[XW-1:0]), 64'd1);
        checkOutput("single_y", 64'(bus.o_l_dst_y[YW-1:0]), 64'd2);
        checkOutput("single_payload", 64'(bus.o_l_payload[PW-1:0]), 64'hAB);
        checkOutput("single_cnt", 64'(bus.o_grant_cnt), 64'd1);
        checkOutput("single_ptr", 64'(dut.rr_ptr), 64'd4);

        $display("[TB] round robin");
        doReset();
        randomizeFields();
        applyStimulus(8'hFF, 4'hF, 1'b1);
        checkOutput("rr_cycle0", 64'(lastReady), 64'h0F);
        randomizeFields();
        applyStimulus(8'hFF, 4'hF, 1'b1);
        checkOutput("rr_cycle1", 64'(lastReady), 64'hF0);
        checkOutput("rr_cnt", 64'(bus.o_grant_cnt), 64'd8);

        $display("[TB] lane backpressure");
        for (int c = 0; c < 5; c++) begin
            randomizeFields();
            applyStimulus(8'hFF, 4'b1110, 1'b1);
            checkOutput("bp_grants", 64'($countones(lastReady)), 64'd3);
        end

        $display("[TB] disable and drain");
        applyStimulus(8'hFF, 4'h0, 1'b1);
        applyStimulus(8'hFF, 4'hF, 1'b0);
        checkOutput("drain_ready", 64'(lastReady), 64'd0);
        checkOutput("drain_valid", 64'(bus.o_l_valid), 64'd0);
        applyStimulus(8'hFF, 4'hF, 1'b0);

        $display("[TB] reset mid-stream");
        randomizeFields();
        applyStimulus(8'hFF, 4'h0, 1'b1);
        doReset();
        randomizeFields();
        applyStimulus(8'hFF, 4'hF, 1'b1);
        checkOutput("rst_first_grant", 64'(lastReady[0]), 64'd1);

        $display("[TB] counter wrap");
        force dut.grant_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.grant_cnt;
        mCnt = 32'hFFFF_FFFE;
        randomizeFields();
        applyStimulus(8'h0F, 4'hF, 1'b1);
        checkOutput("wrap_cnt", 64'(bus.o_grant_cnt), 64'd2);

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            randomizeFields();
            applyStimulus(NUM_REQ'($urandom), NUM_LANE'($urandom),
                          ($urandom_range(0, 7) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mesh_inject_scheduler.md
# mesh_inject_scheduler

Schedules a set of match-engine requesters onto the `NUM_SHARED_MATCH_PE` local injection lanes of one mesh router cluster. Each cycle it grants up to one request per free lane, in round-robin requester order, and registers each granted flit into a per-lane holding stage. The holding stage drives the cluster's `i_l_*` inputs and obeys the router's valid/ready backpressure. One instance sits between the requester group and each `mesh_router_cluster`.

## Interface
- `NUM_REQ`, 8: number of requesters; must be ≥ 1.
- `NUM_LANE`, `` `NUM_SHARED_MATCH_PE ``: number of local injection lanes; must be ≤ `NUM_REQ`.
- `X_LOG2`, `` `MESH_X_SIZE_LOG2 ``: destination X field width.
- `Y_LOG2`, `` `MESH_Y_SIZE_LOG2 ``: destination Y field width.
- `W`, `` `MESH_W ``: payload width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_en` in 1: grant enable; when low, no new grants are issued.
- `req_valid` in NUM_REQ: per-requester request.
- `req_dst_x` in NUM_REQ*X_LOG2: packed destination X per requester.
- `req_dst_y` in NUM_REQ*Y_LOG2: packed destination Y per requester.
- `req_payload` in NUM_REQ*W: packed payload per requester.
- `req_ready` out NUM_REQ: grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `o_l_valid` out NUM_LANE: lane flit valid; connects to the cluster `i_l_valid`.
- `o_l_dst_x` out NUM_LANE*X_LOG2: lane destination X.
- `o_l_dst_y` out NUM_LANE*Y_LOG2: lane destination Y.
- `o_l_payload` out NUM_LANE*W: lane payload.
- `o_l_ready` in NUM_LANE: lane ready; connects from the cluster `i_l_ready`.
- `o_idle` out 1: high when all lanes are empty and no grant is issued this cycle.
- `o_grant_cnt` out 32: total number of accepted requests, wrapping.

## Operation
- **Lane state.** Each lane is either EMPTY or FULL.
  - A lane is *free* this cycle if it is EMPTY, or FULL with `o_l_ready` high (drain and refill in the same cycle).
- **Arbitration.** Arbitration is combinational and runs only when `cfg_en` is high.
  - Scan requesters in circular order starting at the pointer `rr_ptr`.
  - The k-th valid requester found is granted to the k-th free lane, lanes ordered by ascending index.
  - Granting stops when free lanes or valid requesters run out.
- **Grant outputs.** `req_ready[i]` is high only for granted requesters.
  - It depends on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- **Lane update** (registered):
  - Granted lane: loads the requester's `dst_x`, `dst_y` and `payload` and becomes FULL.
  - FULL lane drained with no grant: becomes EMPTY.
  - FULL lane not drained: holds, with all fields stable.
- **Pointer update.** If any grant occurs, `rr_ptr` moves to one past the last granted requester, modulo `NUM_REQ`. Otherwise it holds.
- **Grant counter.** `o_grant_cnt` increases by the number of grants this cycle, with modulo-2^32 wrap.
- **Disable.** With `cfg_en` low:
  - `req_ready` is all zero.
  - FULL lanes still drain normally.
  - `rr_ptr` holds.
- **Address fields.** Destination fields pass through unmodified. No range checking is done.

## Timing
- **Reset values:** all lanes EMPTY, so `o_l_valid` = 0. `rr_ptr` = 0, `o_grant_cnt` = 0, `o_idle` = 1.
  - Lane data registers reset to 0.
  - `req_ready` = 0 while `rst` is high.
- **Latency:** a request accepted at edge T is presented on its lane in the cycle after T. Latency is 1 cycle.
- **Throughput:** one flit per lane per cycle under continuous `o_l_ready`.
- **Stall:** a FULL lane keeps `o_l_valid` high with stable data until `o_l_ready` is seen. It never withdraws.
- **Reset mid-operation:** held flits are discarded and everything returns to reset values immediately. No partial transfer is reported.
- **Fairness:** with all requesters asserting continuously, every requester is granted within ceil(`NUM_REQ`/free lanes) cycles.

## Structure
- Shared package `mesh_pkg`:
  - the lane flit struct `{dst_x, dst_y, payload}`;
  - width constants derived from `MESH_X_SIZE_LOG2`, `MESH_Y_SIZE_LOG2` and `MESH_W`.
- Sub-module `mesh_inject_lane_reg`: one lane's holding register with valid/ready handshake, instantiated `NUM_LANE` times.
- Arbitration, pointer and counter logic stay in the top module.

## Test plan
Defaults for all scenarios: `NUM_REQ`=8, `NUM_LANE`=4, all `o_l_ready` high, `cfg_en` = 1.
- **Single request.** Requester 3 is valid with dst (1,2) and payload 0xAB.
  - Expect `req_ready[3]` high the same cycle.
  - Next cycle: lane 0 is valid with (1,2,0xAB); `o_grant_cnt` = 1; `rr_ptr` = 4.
- **Round-robin fairness.** All 8 requesters valid for 2 cycles.
  - Cycle 0: requesters 0–3 granted to lanes 0–3.
  - Cycle 1: requesters 4–7 granted.
  - `o_grant_cnt` = 8.
- **Lane backpressure.** `o_l_ready[0]` = 0 and lane 0 is FULL.
  - Lane 0 holds its data unchanged for 5 cycles.
  - Only 3 grants are issued per cycle, to lanes 1–3.
- **Disable and drain.** All lanes FULL, `cfg_en` = 0.
  - `req_ready` = 0.
  - Lanes empty after one ready cycle; `o_idle` rises.
- **Reset mid-stream.** Assert `rst` while lanes are FULL.
  - Same cycle: `o_l_valid` = 0, `o_grant_cnt` = 0, `rr_ptr` = 0.
  - First grant after release goes to requester 0.
- **Counter wrap.** Preload `o_grant_cnt` to 0xFFFFFFFE via force, then grant 4 requesters in one cycle.
  - Expect `o_grant_cnt` = 0x00000002.
